multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencer for the TOP datapath. It replaces the free-running one-instruction-per-clock PC advance with a fetch/decode/execute/writeback FSM. It drives the instruction-fetch handshake, IR load, PC advance, register-file write enable and the ALUOp field consumed by ALUcontrol. It also tracks halt, illegal-opcode and fetch-timeout conditions, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
- ACK_TIMEOUT, 16, max cycles FETCH waits for imem_ack before fault (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level enable; controller leaves IDLE while high
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- opcode  in  6  IR[0:5], valid from the cycle after ir_we
- ir_we  out  1  load instruction register (1-cycle pulse)
- pc_we  out  1  advance PC (1-cycle pulse)
- rf_we  out  1  register-file write enable
- alu_op  out  6  ALUOp to ALUcontrol
- busy  out  1  high in any state except IDLE/HALT
- halted  out  1  high in HALT
- illegal  out  1  sticky: an unsupported opcode was decoded
- fetch_err  out  1  sticky: fetch timed out
- retired  out  CNT_W  count of completed R-type instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: all strobes low. Goes to FETCH when run=1.
- FETCH: imem_req=1. Timeout counter increments each cycle.
  - imem_ack=1: ir_we=1 this cycle, go to DECODE, clear the counter.
  - Counter reaches ACK_TIMEOUT without ack: set fetch_err, go to HALT.
  - Ack in the same cycle as expiry: ack wins.
- DECODE, by opcode:
  - OP_RTYPE (6'h00): go to EXEC.
  - OP_HALT (6'h3F): go to HALT. PC is not advanced and retired is not incremented.
  - Any other opcode: set illegal, pulse pc_we, go to FETCH (or IDLE if run=0). Instruction is skipped and not counted.
- EXEC: alu_op=ALUOP_RTYPE. Go to WB.
- WB: alu_op=ALUOP_RTYPE, rf_we=1, pc_we=1, retired+1. Go to FETCH if run=1, else IDLE.
- alu_op=ALUOP_NOP (6'h00) in all other states.
- HALT: absorbing. Exits only on rst. run and imem_ack are ignored.
- run dropping mid-instruction: the current instruction completes; the FSM checks run only at IDLE and at instruction end.
- imem_ack outside FETCH is ignored.
- retired wraps modulo 2^CNT_W.

## Timing
- Reset (rst high at an edge) puts the FSM in IDLE regardless of state. Output values after reset:
  - imem_req, ir_we, pc_we, rf_we: 0
  - alu_op: 0
  - busy, halted: 0
  - illegal, fetch_err: 0
  - retired: 0
  - timeout counter: 0
- All outputs are Moore, decoded from registered state. Exception: ir_we = (state==FETCH) & imem_ack.
- R-type instruction with ack in the first FETCH cycle takes 4 cycles (FETCH, DECODE, EXEC, WB). Each extra wait cycle adds 1.
- Back-to-back R-type instructions with zero-wait ack: one pc_we every 4 cycles.
- Skipped illegal instruction takes 2 cycles.
- Reset to first imem_req: 1 cycle after the first edge with run=1.

## Structure
- Package ctrl_pkg holds:
  - state_t enum
  - OP_RTYPE, OP_HALT
  - ALUOP_NOP, ALUOP_RTYPE (6 bits, matching the Control/ALUcontrol encoding)
- Single module; no sub-module needed. The timeout counter and retired counter are inline registers.
- TOP integration:
  - pc_we gates the PC register.
  - rf_we replaces Control's we.
  - alu_op replaces Control's ALUOp.

## Test plan
- Reset, then run=1, three R-type opcodes, ack same cycle as req → pc_we at cycles 4, 8, 12; rf_we only in WB; retired=3; alu_op=ALUOP_RTYPE only in EXEC/WB.
- Ack delayed 5 cycles, ACK_TIMEOUT=16 → imem_req held 6 cycles, ir_we single pulse, no fetch_err.
- No ack for 16 cycles → fetch_err=1, halted=1, busy=0; later acks and run toggles cause no change until rst.
- Opcode 6'h2A then R-type → illegal=1 stays set, pc_we pulses in DECODE, retired=1, rf_we only for the R-type.
- Opcode 6'h3F → halted=1 after DECODE, no pc_we; rst in the next cycle → all outputs return to reset values and state is IDLE.
- run dropped during EXEC → WB completes with pc_we=1 and rf_we=1, then IDLE with no further imem_req.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle sequencer and its datapath.
package ctrl_pkg;

   // Sequencer states; one instruction walks FETCH -> DECODE -> EXEC -> WB.
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   // Opcodes the sequencer understands; everything else is skipped as illegal.
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // ALUOp encodings shared with Control/ALUcontrol.
   localparam logic [5:0] ALUOP_NOP   = 6'h00;
   localparam logic [5:0] ALUOP_RTYPE = 6'h02;

   // True for opcodes that are neither R-type nor HALT.
   function automatic logic is_illegal_op(input logic [5:0] op);
      return (op != OP_RTYPE) && (op != OP_HALT);
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the TOP datapath.
// Drives the fetch handshake, IR/PC/RF write strobes and ALUOp, and tracks
// halt, illegal-opcode and fetch-timeout conditions.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [5:0]       opcode,
   output logic             ir_we,
   output logic             pc_we,
   output logic             rf_we,
   output logic [5:0]       alu_op,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic             fetch_err,
   output logic [CNT_W-1:0] retired
);

   // Counter wide enough to hold ACK_TIMEOUT; the last FETCH cycle allowed
   // without an ack is the one where the counter equals ACK_TIMEOUT-1.
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

   state_t        state;
   state_t        next_state;
   logic [TW-1:0] tmo_cnt;
   logic          fetch_expire;
   logic          decode_illegal;

   assign fetch_expire   = (state == S_FETCH) && !imem_ack && (tmo_cnt == TMO_LAST);
   assign decode_illegal = (state == S_DECODE) && is_illegal_op(opcode);

   // State register; reset always returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Next-state decode; run is only consulted in IDLE and at instruction end.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (run) next_state = S_FETCH;
         S_FETCH: begin
            if (imem_ack)          next_state = S_DECODE;
            else if (fetch_expire) next_state = S_HALT;
         end
         S_DECODE: begin
            if (opcode == OP_RTYPE)     next_state = S_EXEC;
            else if (opcode == OP_HALT) next_state = S_HALT;
            else                        next_state = run ? S_FETCH : S_IDLE;
         end
         S_EXEC:   next_state = S_WB;
         S_WB:     next_state = run ? S_FETCH : S_IDLE;
         S_HALT:   next_state = S_HALT;
         default:  next_state = S_IDLE;
      endcase
   end

   // Moore strobes decoded from state; ir_we alone also looks at imem_ack.
   always_comb begin
      imem_req = (state == S_FETCH);
      ir_we    = (state == S_FETCH) && imem_ack;
      pc_we    = (state == S_WB) || decode_illegal;
      rf_we    = (state == S_WB);
      alu_op   = ALUOP_NOP;
      if ((state == S_EXEC) || (state == S_WB)) alu_op = ALUOP_RTYPE;
      busy     = (state != S_IDLE) && (state != S_HALT);
      halted   = (state == S_HALT);
   end

   // Fetch wait counter: counts unanswered FETCH cycles, clears otherwise.
   always_ff @(posedge clk) begin
      if (rst)                                                       tmo_cnt <= '0;
      else if ((state == S_FETCH) && !imem_ack && (tmo_cnt != TMO_LAST)) tmo_cnt <= tmo_cnt + 1'b1;
      else                                                           tmo_cnt <= '0;
   end

   // Sticky fault flags and the retired R-type counter (wraps naturally).
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal   <= 1'b0;
         fetch_err <= 1'b0;
         retired   <= '0;
      end else begin
         if (decode_illegal)   illegal   <= 1'b1;
         if (fetch_expire)     fetch_err <= 1'b1;
         if (state == S_WB)    retired   <= retired + 1'b1;
      end
   end

endmodule
